conv3x3_mac_pipeline: RTL and testbench
=======================================

// Module: conv3x3_mac_pipeline
// PURPOSE
//  Downstream consumer of the 3x3 window buffer. Takes one 9-tap signed window per valid cycle.
//  Computes the weighted sum with 9 programmable coefficients, adds a bias, then shifts with rounding.
//  Applies optional ReLU and saturates to 16 bits, emitting one pixel per window.
//  Counts outputs per frame, raises frame_done, and swaps coefficient banks only between frames.
// PARAMETERS
//  OUT_W   16  output sample width (signed)
//  ACC_W   36  accumulator width (9 x 32-bit products, no overflow)
// PORTS
//  clk           in   1   clock, all logic on rising edge
//  rst           in   1   reset, asynchronous, active-high
//  valid_in      in   1   window taps valid this cycle
//  data_in0..8   in   16  signed taps, row-major (0=top-left, 8=bottom-right)
//  img_width     in   8   frame width in pixels; sampled at frame start
//  img_height    in   8   frame height in pixels; sampled at frame start
//  padding_mode  in   2   01: zero padding (W*H outputs); any other value: no padding ((W-2)*(H-2) outputs)
//  coef_wr_en    in   1   write coef_data into shadow bank at coef_addr
//  coef_addr     in   4   0..8 select tap; 9..15 ignored
//  coef_data     in   16  signed coefficient
//  coef_commit   in   1   request shadow->active bank copy
//  bias          in   32  signed bias, sign-extended to ACC_W; sampled in stage 3
//  shift_amt     in   4   right shift 0..15 applied after bias; sampled in stage 4
//  relu_en       in   1   1: negative results forced to 0; sampled in stage 4
//  data_out      out  16  signed result
//  valid_out     out  1   data_out valid, single-cycle per result
//  frame_done    out  1   1-cycle pulse coincident with the last valid_out of a frame
//  busy          out  1   frame in progress (first valid_in .. last valid_out)
//  coef_pending  out  1   commit requested but not yet applied
// BEHAVIOUR
//  Reset: data_out=0, valid_out=0, frame_done=0, busy=0, coef_pending=0.
//   Reset also clears both coefficient banks, all pipeline regs and the output counter.
//   Reset asserted mid-frame discards all in-flight data; the next valid_in starts a new frame.
//  Pipeline latency: 4 cycles, valid_in at cycle N -> valid_out at N+4. Full throughput, no backpressure.
//   S1: p[k] = data_in[k] * coef_active[k], each 32-bit signed.
//   S2: three row sums r0=p0+p1+p2, r1=p3+p4+p5, r2=p6+p7+p8, each ACC_W signed.
//   S3: acc = r0 + r1 + r2 + sext(bias).
//   S4: if shift_amt>0, acc += 1<<(shift_amt-1), then arithmetic shift right by shift_amt.
//    If relu_en and the result is negative, the result becomes 0.
//    Saturate to [-32768, 32767].
//  The valid bit travels alongside the data in each stage; invalid cycles keep the stage data regs unchanged.
//  Frame control (states IDLE / ACTIVE):
//   IDLE -> ACTIVE on valid_in. The same cycle latches img_width, img_height and padding_mode.
//    It also sets the expected count: E = W*H when padding_mode==01, else (W-2)*(H-2), 16-bit.
//   ACTIVE: a 16-bit out_cnt increments on each valid_out.
//    When the valid_out with out_cnt==E-1 fires, frame_done pulses, out_cnt returns to 0, and state returns to IDLE.
//   busy = (state==ACTIVE).
//   Zero-size frame: if E==0 (W<3 or H<3 with no padding, or W or H = 0), no frame is started.
//    Data is still processed and emitted, but frame_done never pulses.
//  Coefficients: coef_wr_en writes the shadow bank immediately; addr>=9 has no effect.
//   coef_commit sets coef_pending.
//   In any cycle where state==IDLE, no valid in S1..S4, no valid_in, and coef_pending=1:
//    active bank <= shadow bank, and coef_pending clears the next cycle.
//   A commit requested mid-frame waits for the frame end; a frame never mixes coefficient sets.
//   coef_wr_en in the same cycle as the copy: the copy uses the pre-write shadow value.
//   coef_commit in the same cycle as the copy: coef_pending stays 1, so one more copy follows.
//  valid_in arriving on the same cycle as frame_done starts the next frame with no bubble.
// TESTING
//  1. Identity: coef4=1, others 0; bias=0, shift=0; window 1..9 -> data_out=5 at exactly 4 cycles after valid_in.
//  2. Rounding/sat: all coef=1, taps=100, bias=6, shift=3 -> 906 => (906+4)>>3 = 113.
//     All coef=32767, taps=32767 -> data_out=32767.
//  3. ReLU: all coef=-1, taps=10, relu_en=1 -> 0; same with relu_en=0 -> -90.
//  4. Frame: W=5, H=4, mode 00, 6 back-to-back windows -> 6 valid_out; frame_done on the 6th; busy low after.
//     Repeat with mode 01 and 20 windows -> frame_done on the 20th.
//  5. Mid-frame commit: load new coefs, pulse commit at window 3 of 6 -> outputs 1..6 all use old set.
//     The next frame uses the new set; coef_pending drops at the gap.
//  6. Async rst asserted mid-frame with 3 windows in flight -> outputs 0 immediately, no valid_out afterwards.
//     Next frame counts from 0.

Source files
------------

// File: rtl/conv3x3_mac_pipeline_if.sv
// Port bundle for the 3x3 convolution MAC pipeline: window input, coefficient load,
// per-frame configuration and the result stream.
interface conv3x3_mac_pipeline_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16
);
  logic                     valid_in;
  logic signed [DATA_W-1:0] data_in [9];
  logic [7:0]               img_width;
  logic [7:0]               img_height;
  logic [1:0]               padding_mode;
  logic                     coef_wr_en;
  logic [3:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_commit;
  logic signed [31:0]       bias;
  logic [3:0]               shift_amt;
  logic                     relu_en;
  logic signed [OUT_W-1:0]  data_out;
  logic                     valid_out;
  logic                     frame_done;
  logic                     busy;
  logic                     coef_pending;

  modport master (
    output valid_in, data_in, img_width, img_height, padding_mode,
           coef_wr_en, coef_addr, coef_data, coef_commit,
           bias, shift_amt, relu_en,
    input  data_out, valid_out, frame_done, busy, coef_pending
  );

  modport slave (
    input  valid_in, data_in, img_width, img_height, padding_mode,
           coef_wr_en, coef_addr, coef_data, coef_commit,
           bias, shift_amt, relu_en,
    output data_out, valid_out, frame_done, busy, coef_pending
  );
endinterface

// File: rtl/conv3x3_mac_pipeline.sv
// 4-stage 3x3 convolution MAC: multiply, row sums, bias, round/ReLU/saturate.
// Frame counter drives frame_done; coefficient banks only swap while fully idle.
module conv3x3_mac_pipeline #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = 36
) (
  input logic                    clk,
  input logic                    rst,
  conv3x3_mac_pipeline_if.slave  bus
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    $signed({{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic signed [COEF_W-1:0] r_coef_shadow [9];
  logic signed [COEF_W-1:0] r_coef_active [9];
  logic                     r_coef_pending;
  logic signed [PROD_W-1:0] r_prod_p1 [9];
  logic signed [ACC_W-1:0]  r_row_p2 [3];
  logic signed [ACC_W-1:0]  r_acc_p3;
  logic signed [OUT_W-1:0]  r_dout_p4;
  logic                     r_vld_p1;
  logic                     r_vld_p2;
  logic                     r_vld_p3;
  logic                     r_vld_p4;
  logic [15:0]              r_exp_cnt;
  logic [15:0]              r_out_cnt;
  logic [15:0]              w_exp_cnt;
  logic                     w_start;
  logic                     w_last;
  logic                     w_copy;
  logic signed [ACC_W-1:0]  w_bias_ext;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return $signed({{(ACC_W-PROD_W){p[PROD_W-1]}}, p});
  endfunction

  function automatic logic signed [PROD_W-1:0] mul_tap(input logic signed [DATA_W-1:0] d,
                                                       input logic signed [COEF_W-1:0] c);
    logic signed [PROD_W-1:0] de;
    logic signed [PROD_W-1:0] ce;
    de = PROD_W'(d);
    ce = PROD_W'(c);
    return de * ce;
  endfunction

  // Round half up before the arithmetic shift; shift of 0 passes through.
  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a,
                                                          input logic [3:0] sh);
    logic signed [ACC_W-1:0] t;
    t = a;
    if (sh != 4'd0) t = a + (ACC_W'(1) << (sh - 4'd1));
    return t >>> sh;
  endfunction

  function automatic logic signed [OUT_W-1:0] relu_sat(input logic signed [ACC_W-1:0] a,
                                                       input logic relu);
    logic signed [ACC_W-1:0] v;
    v = (relu && (a < 0)) ? '0 : a;
    if (v > SAT_MAX)      return {1'b0, {(OUT_W-1){1'b1}}};
    else if (v < SAT_MIN) return {1'b1, {(OUT_W-1){1'b0}}};
    else                  return v[OUT_W-1:0];
  endfunction

  assign w_bias_ext = $signed({{(ACC_W-32){bus.bias[31]}}, bus.bias});

  // Coefficient banks; the copy reads the shadow before any same-cycle write lands.
  assign w_copy = (r_state == S_IDLE) && r_coef_pending && !bus.valid_in &&
                  !(r_vld_p1 || r_vld_p2 || r_vld_p3 || r_vld_p4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) begin
        r_coef_shadow[k] <= '0;
        r_coef_active[k] <= '0;
      end
      r_coef_pending <= 1'b0;
    end else begin
      if (bus.coef_wr_en && (bus.coef_addr < 4'd9))
        r_coef_shadow[bus.coef_addr] <= bus.coef_data;
      if (w_copy) begin
        for (int k = 0; k < 9; k++) r_coef_active[k] <= r_coef_shadow[k];
      end
      r_coef_pending <= (r_coef_pending && !w_copy) || bus.coef_commit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
      r_vld_p4 <= 1'b0;
      for (int k = 0; k < 9; k++) r_prod_p1[k] <= '0;
      for (int k = 0; k < 3; k++) r_row_p2[k] <= '0;
      r_acc_p3  <= '0;
      r_dout_p4 <= '0;
    end else begin
      r_vld_p1 <= bus.valid_in;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
      r_vld_p4 <= r_vld_p3;
      // Stage 1: per-tap products
      if (bus.valid_in) begin
        for (int k = 0; k < 9; k++) r_prod_p1[k] <= mul_tap(bus.data_in[k], r_coef_active[k]);
      end
      // Stage 2: row sums
      if (r_vld_p1) begin
        for (int k = 0; k < 3; k++)
          r_row_p2[k] <= sext_prod(r_prod_p1[3*k]) + sext_prod(r_prod_p1[3*k+1]) +
                         sext_prod(r_prod_p1[3*k+2]);
      end
      // Stage 3: total plus bias
      if (r_vld_p2) r_acc_p3 <= r_row_p2[0] + r_row_p2[1] + r_row_p2[2] + w_bias_ext;
      // Stage 4: round, shift, ReLU, saturate
      if (r_vld_p3) r_dout_p4 <= relu_sat(round_shift(r_acc_p3, bus.shift_amt), bus.relu_en);
    end
  end

  always_comb begin
    w_exp_cnt = '0;
    if (bus.padding_mode == 2'b01)
      w_exp_cnt = {8'd0, bus.img_width} * {8'd0, bus.img_height};
    else if ((bus.img_width >= 8'd3) && (bus.img_height >= 8'd3))
      w_exp_cnt = ({8'd0, bus.img_width} - 16'd2) * ({8'd0, bus.img_height} - 16'd2);
  end

  assign w_start = bus.valid_in && (w_exp_cnt != 16'd0);
  assign w_last  = (r_state == S_ACTIVE) && r_vld_p4 && (r_out_cnt == r_exp_cnt - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_last)  w_state_nxt = w_start ? S_ACTIVE : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = (r_state == S_ACTIVE);
    bus.frame_done   = w_last;
    bus.valid_out    = r_vld_p4;
    bus.data_out     = r_dout_p4;
    bus.coef_pending = r_coef_pending;
  end

  // A new frame can latch its size on the very cycle the previous one finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp_cnt <= '0;
      r_out_cnt <= '0;
    end else begin
      if (((r_state == S_IDLE) || w_last) && w_start) r_exp_cnt <= w_exp_cnt;
      if ((r_state == S_ACTIVE) && r_vld_p4)
        r_out_cnt <= w_last ? 16'd0 : r_out_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_conv3x3_mac_pipeline.sv
// Scoreboard bench for conv3x3_mac_pipeline: directed windows push expected results,
// a negedge monitor pops and compares data, frame_done and arrival cycle.
module tb_conv3x3_mac_pipeline;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   vo_seen = 0;

  typedef struct {
    int data;
    bit fd;
    int cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv3x3_mac_pipeline_if bus ();
  conv3x3_mac_pipeline dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic check(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.valid_out) begin
        vo_seen++;
        if (sb.size() == 0) check("unexpected_valid_out", 1, 0);
        else begin
          e = sb.pop_front();
          check("data_out", bus.data_out, e.data);
          check("frame_done", bus.frame_done, e.fd);
          check("latency_cycle", cyc, e.cyc);
        end
      end else if (bus.frame_done) check("frame_done_without_valid", 1, 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      bus.valid_in    = 1'b0;
      bus.coef_wr_en  = 1'b0;
      bus.coef_commit = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input int base, input int step, input int expv, input bit fd,
                      input bit commit);
    exp_t e;
    bus.valid_in    = 1'b1;
    bus.coef_commit = commit;
    for (int k = 0; k < 9; k++) bus.data_in[k] = 16'(base + step * k);
    e.data = expv;
    e.fd   = fd;
    e.cyc  = cyc + 4;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.valid_in    = 1'b0;
    bus.coef_commit = 1'b0;
  endtask

  task automatic write_coefs(input int others, input int center);
    for (int k = 0; k < 9; k++) begin
      bus.coef_wr_en = 1'b1;
      bus.coef_addr  = 4'(k);
      bus.coef_data  = 16'((k == 4) ? center : others);
      @(posedge clk); #1;
    end
    bus.coef_wr_en = 1'b0;
  endtask

  task automatic wait_pending_clear(input string name);
    int n;
    n = 0;
    while (bus.coef_pending && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, bus.coef_pending, 0);
  endtask

  task automatic load_coefs(input int others, input int center);
    write_coefs(others, center);
    bus.coef_commit = 1'b1;
    @(posedge clk); #1;
    bus.coef_commit = 1'b0;
    check("coef_pending_set", bus.coef_pending, 1);
    wait_pending_clear("coef_pending_clear");
  endtask

  task automatic cfg(input int b, input int sh, input bit relu);
    bus.bias      = 32'(b);
    bus.shift_amt = 4'(sh);
    bus.relu_en   = relu;
  endtask

  task automatic frame_size(input int w, input int h, input int mode);
    bus.img_width    = 8'(w);
    bus.img_height   = 8'(h);
    bus.padding_mode = 2'(mode);
  endtask

  initial begin
    int n;
    bus.valid_in = 1'b0;
    for (int k = 0; k < 9; k++) bus.data_in[k] = '0;
    frame_size(0, 0, 0);
    bus.coef_wr_en = 1'b0; bus.coef_addr = '0; bus.coef_data = '0; bus.coef_commit = 1'b0;
    cfg(0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", bus.data_out, 0);
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_coef_pending", bus.coef_pending, 0);
    rst = 1'b0;
    idle(2);

    // Identity on a zero-size frame: result is the centre tap, no frame started
    load_coefs(0, 1);
    send(1, 1, 5, 1'b0, 1'b0);
    idle(6);
    check("zero_size_busy", bus.busy, 0);

    // Rounding and saturation
    load_coefs(1, 1);
    cfg(6, 3, 1'b0);
    send(100, 0, 113, 1'b0, 1'b0);
    idle(6);
    cfg(0, 3, 1'b0);
    send(-100, 0, -112, 1'b0, 1'b0);
    idle(6);
    cfg(0, 0, 1'b0);
    load_coefs(32767, 32767);
    send(32767, 0, 32767, 1'b0, 1'b0);
    idle(6);
    load_coefs(-32767, -32767);
    send(32767, 0, -32768, 1'b0, 1'b0);
    idle(6);

    // ReLU on and off
    load_coefs(-1, -1);
    cfg(0, 0, 1'b1);
    send(10, 0, 0, 1'b0, 1'b0);
    idle(6);
    cfg(0, 0, 1'b0);
    send(10, 0, -90, 1'b0, 1'b0);
    idle(6);

    // Frames: 5x4 without padding (6 outputs), then with padding (20 outputs)
    load_coefs(0, 1);
    frame_size(5, 4, 0);
    for (int i = 0; i < 6; i++) begin
      send(i + 1, 0, i + 1, i == 5, 1'b0);
      if (i == 2) check("busy_mid_frame", bus.busy, 1);
    end
    idle(6);
    check("busy_after_frame", bus.busy, 0);
    frame_size(5, 4, 1);
    for (int i = 0; i < 20; i++) send(3 * i - 30, 0, 3 * i - 30, i == 19, 1'b0);
    idle(6);
    check("busy_after_padded_frame", bus.busy, 0);

    // Two frames back to back: the second starts on the first frame_done cycle
    frame_size(5, 4, 0);
    for (int i = 0; i < 12; i++) send(i + 40, 0, i + 40, (i == 5) || (i == 11), 1'b0);
    idle(6);
    check("busy_after_back_to_back", bus.busy, 0);

    // Commit during a frame waits for the frame to end
    write_coefs(0, 2);
    for (int i = 0; i < 6; i++) begin
      send(i + 1, 0, i + 1, i == 5, i == 2);
      if (i == 4) check("coef_pending_mid_frame", bus.coef_pending, 1);
    end
    wait_pending_clear("coef_pending_after_frame");
    idle(2);
    for (int i = 0; i < 6; i++) send(i + 1, 0, 2 * (i + 1), i == 5, 1'b0);
    idle(6);

    // Asynchronous reset with three windows in flight
    for (int i = 0; i < 3; i++) send(i + 7, 0, 2 * (i + 7), 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    sb.delete();
    check("async_rst_data_out", bus.data_out, 0);
    check("async_rst_valid_out", bus.valid_out, 0);
    check("async_rst_busy", bus.busy, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    vo_seen = 0;
    idle(8);
    check("no_valid_after_reset", vo_seen, 0);
    frame_size(0, 0, 0);
    send(7, 1, 0, 1'b0, 1'b0);
    idle(6);
    load_coefs(0, 1);
    frame_size(5, 4, 0);
    for (int i = 0; i < 6; i++) send(i - 3, 0, i - 3, i == 5, 1'b0);
    idle(6);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
